// File: rtl/led_mode_sequencer_if.sv
// Button/LED signal bundle for led_mode_sequencer.
// The slave modport is the sequencer; the master side drives the raw button.
interface led_mode_sequencer_if;
  logic       btn_in;
  logic       led_out;
  logic [1:0] mode_o;
  logic       btn_press_o;

  modport master (
    output btn_in,
    input  led_out,
    input  mode_o,
    input  btn_press_o
  );

  modport slave (
    input  btn_in,
    output led_out,
    output mode_o,
    output btn_press_o
  );
endinterface

// File: rtl/led_mode_sequencer.sv
// Pushbutton-driven LED mode sequencer: sync + debounce the button, step
// OFF/SLOW/FAST/BREATHE on each press and drive a registered LED pattern.
module led_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
  parameter int unsigned SLOW_BIT        = 26,
  parameter int unsigned FAST_BIT        = 23,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned BREATH_BIT      = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  led_mode_sequencer_if.slave  bus
);

  localparam int unsigned        DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SLOW    = 2'd1,
    MODE_FAST    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic            sync1_q, sync2_q;
  logic            db_state_q, db_state_d;
  logic            db_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q;
  logic            rise;
  mode_e           state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            led_q, led_d;
  logic [PWM_BITS-1:0] ramp, duty;

  // The count reaching DB_LAST on a mismatching cycle is the Nth stable cycle.
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = '0;
    if (sync2_q != db_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_state_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign rise = db_state_q & ~db_prev_q;

  always_comb begin
    state_d = state_q;
    if (rise) begin
      case (state_q)
        MODE_OFF:     state_d = MODE_SLOW;
        MODE_SLOW:    state_d = MODE_FAST;
        MODE_FAST:    state_d = MODE_BREATHE;
        MODE_BREATHE: state_d = MODE_OFF;
        default:      state_d = MODE_OFF;
      endcase
    end
  end

  assign cnt_d = cnt_q + 32'd1;

  always_comb begin
    ramp  = cnt_q[BREATH_BIT-1 -: PWM_BITS];
    duty  = cnt_q[BREATH_BIT] ? ~ramp : ramp;
    led_d = 1'b0;
    case (state_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_SLOW:    led_d = cnt_q[SLOW_BIT];
      MODE_FAST:    led_d = cnt_q[FAST_BIT];
      MODE_BREATHE: led_d = (cnt_q[PWM_BITS-1:0] < duty);
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_state_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= MODE_OFF;
      cnt_q      <= '0;
      led_q      <= 1'b0;
    end else begin
      sync1_q    <= bus.btn_in;
      sync2_q    <= sync1_q;
      db_state_q <= db_state_d;
      db_prev_q  <= db_state_q;
      db_cnt_q   <= db_cnt_d;
      press_q    <= rise;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
    end
  end

  assign bus.led_out     = led_q;
  assign bus.mode_o      = state_q;
  assign bus.btn_press_o = press_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Scoreboard bench for led_mode_sequencer with small debounce/pattern params.
module tb_led_mode_sequencer;

  localparam int unsigned DC = 4;

  typedef struct {
    int unsigned edge_n;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_mode_sequencer_if bus();

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES(DC),
    .SLOW_BIT(4),
    .FAST_BIT(2),
    .PWM_BITS(2),
    .BREATH_BIT(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned edge_cnt = 0;
  logic [31:0] cnt_m;
  logic [1:0]  mode_m;
  logic        led_m;
  logic [1:0]  exp_mode_s = 2'd0;
  bit          load_pending = 1'b0;

  function automatic logic led_fn(input logic [1:0] m, input logic [31:0] c);
    logic [1:0] ramp, duty;
    ramp = c[5:4];
    duty = c[6] ? ~ramp : ramp;
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return c[4];
      2'd2:    return c[2];
      default: return (c[1:0] < duty);
    endcase
  endfunction

  // Reference model, advanced on every rising edge.
  always @(posedge clk) begin : model
    logic [31:0] cin;
    edge_cnt = edge_cnt + 1;
    cin = load_pending ? 32'hFFFF_FFF0 : cnt_m;
    if (reset) begin
      cnt_m  <= '0;
      mode_m <= 2'd0;
      led_m  <= 1'b0;
    end else begin
      led_m <= led_fn(mode_m, cin);
      cnt_m <= cin + 32'd1;
      if (sb.size() > 0 && sb[0].edge_n == edge_cnt) mode_m <= sb[0].mode;
    end
  end

  // Monitor: per-cycle LED/mode checks plus press-pulse scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (edge_cnt > 0) begin
      checks++;
      if (bus.led_out !== led_m) begin
        failures++;
        $display("FAIL led_out edge=%0d got=%b exp=%b", edge_cnt, bus.led_out, led_m);
      end
      checks++;
      if (bus.mode_o !== mode_m) begin
        failures++;
        $display("FAIL mode_o edge=%0d got=%0d exp=%0d", edge_cnt, bus.mode_o, mode_m);
      end
      if (bus.btn_press_o === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_press edge=%0d got=1 exp=0", edge_cnt);
        end else begin
          e = sb.pop_front();
          if (e.edge_n != edge_cnt || bus.mode_o !== e.mode) begin
            failures++;
            $display("FAIL press edge got=%0d exp=%0d mode got=%0d exp=%0d",
                     edge_cnt, e.edge_n, bus.mode_o, e.mode);
          end
        end
      end else if (bus.btn_press_o !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL press_level edge=%0d got=%b exp=0", edge_cnt, bus.btn_press_o);
      end else if (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
        checks++;
        failures++;
        e = sb.pop_front();
        $display("FAIL missed_press edge=%0d got=0 exp_edge=%0d", edge_cnt, e.edge_n);
      end
    end
  end

  // Pulse expected DC+3 edges after the first high sample.
  task automatic press(input int unsigned hold, input bit expect_pulse);
    bus.btn_in = 1'b1;
    if (expect_pulse) begin
      exp_mode_s = exp_mode_s + 2'd1;
      sb.push_back('{edge_n: edge_cnt + DC + 3, mode: exp_mode_s});
    end
    repeat (hold) @(negedge clk);
    bus.btn_in = 1'b0;
    repeat (DC + 8) @(negedge clk);
  endtask

  task automatic bounce();
    logic pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.btn_in = pat[i];
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.btn_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    press(20, 1'b1);                 // -> SLOW
    repeat (40) @(negedge clk);

    bounce();
    repeat (DC + 8) @(negedge clk);
    bounce();
    press(6, 1'b1);                  // -> FAST

    for (int i = 0; i < 4; i++) begin
      press(10, 1'b1);               // BREATHE, OFF, SLOW, FAST
      repeat (20) @(negedge clk);
    end
    press(10, 1'b1);                 // -> BREATHE
    repeat (140) @(negedge clk);
    press(10, 1'b1);                 // -> OFF

    // Reset two cycles into a held press: partial debounce is discarded.
    bus.btn_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset      = 1'b0;
    exp_mode_s = 2'd1;
    sb.push_back('{edge_n: edge_cnt + DC + 3, mode: 2'd1});
    repeat (10) @(negedge clk);
    bus.btn_in = 1'b0;
    repeat (DC + 8) @(negedge clk);

    // Counter wrap in SLOW mode.
    repeat (5) @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFF0;
    load_pending = 1'b1;
    release dut.cnt_q;
    @(negedge clk);
    load_pending = 1'b0;
    repeat (60) @(negedge clk);

    repeat (DC + 10) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_press got=%0d exp=0 outstanding", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
